fetch_unit: RTL

Parametrised instruction fetch stage: holds the fetch PC, issues in-order word requests to instruction memory over a valid/ready request channel, buffers returning instructions with their PCs in a small queue, and presents them to decode over a valid/ready output. It supports redirects for branches, jumps and traps, and squashes responses that were in flight when a redirect occurred. It sits between instruction memory and the decode stage.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory request/response, redirect input
// and the decode-facing output channel.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;

   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
             redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
             redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch stage with credit-limited requests, a PC tag queue
// for outstanding requests, a fall-through fetch queue and redirect squashing.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              FQ_DEPTH = 4
) (
   input logic         clk,
   input logic         rst,
   fetch_unit_if.master bus
);

   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = $clog2(FQ_DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   fq_count_q, fq_count_d;
   logic [PW-1:0]   fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
   logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
   logic [XLEN-1:0] fq_instr_q [FQ_DEPTH];
   logic [XLEN-1:0] fq_instr_d [FQ_DEPTH];
   logic [XLEN-1:0] fq_pc_q    [FQ_DEPTH];
   logic [XLEN-1:0] fq_pc_d    [FQ_DEPTH];
   logic [XLEN-1:0] tag_pc_q   [FQ_DEPTH];
   logic [XLEN-1:0] tag_pc_d   [FQ_DEPTH];

   logic req_valid, req_fire, resp_push, out_pop, fq_empty;

   // A request is only issued when a queue slot is guaranteed for its response.
   assign fq_empty  = (fq_count_q == '0);
   assign req_valid = !rst && !bus.redirect_valid &&
                      (({1'b0, inflight_q} + {1'b0, fq_count_q}) < DEPTH_W);
   assign req_fire  = req_valid && bus.imem_req_ready;
   assign resp_push = bus.imem_resp_valid && (discard_q == '0) && !bus.redirect_valid;
   assign out_pop   = !fq_empty && bus.out_ready;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.out_valid      = !fq_empty;
   assign bus.out_instr      = fq_empty ? '0 : fq_instr_q[fq_rd_q];
   assign bus.out_pc         = fq_empty ? '0 : fq_pc_q[fq_rd_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
      discard_d  = discard_q;
      fq_count_d = fq_count_q;
      fq_rd_d    = fq_rd_q;
      fq_wr_d    = fq_wr_q;
      tag_rd_d   = tag_rd_q;
      tag_wr_d   = tag_wr_q;
      fq_instr_d = fq_instr_q;
      fq_pc_d    = fq_pc_q;
      tag_pc_d   = tag_pc_q;

      if (req_fire) begin
         tag_pc_d[tag_wr_q] = fetch_pc_q;
         tag_wr_d           = tag_wr_q + PW'(1);
         fetch_pc_d         = fetch_pc_q + XLEN'(4);
      end
      if (bus.imem_resp_valid) begin
         tag_rd_d = tag_rd_q + PW'(1);
         if (discard_q != '0) begin
            discard_d = discard_q - CW'(1);
         end
      end

      // Redirect drops the queue and marks every still-outstanding response as stale.
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
         discard_d  = inflight_q - CW'(bus.imem_resp_valid);
         fq_count_d = '0;
         fq_rd_d    = '0;
         fq_wr_d    = '0;
      end else begin
         if (resp_push) begin
            fq_instr_d[fq_wr_q] = bus.imem_resp_data;
            fq_pc_d[fq_wr_q]    = tag_pc_q[tag_rd_q];
            fq_wr_d             = fq_wr_q + PW'(1);
         end
         if (out_pop) begin
            fq_rd_d = fq_rd_q + PW'(1);
         end
         fq_count_d = fq_count_q + CW'(resp_push) - CW'(out_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         fq_count_q <= '0;
         fq_rd_q    <= '0;
         fq_wr_q    <= '0;
         tag_rd_q   <= '0;
         tag_wr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         fq_count_q <= fq_count_d;
         fq_rd_q    <= fq_rd_d;
         fq_wr_q    <= fq_wr_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
         fq_instr_q <= fq_instr_d;
         fq_pc_q    <= fq_pc_d;
         tag_pc_q   <= tag_pc_d;
      end
   end

endmodule
